// File: rtl/bsg_axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among num_req_p requesters.
// One single-beat read or write is in flight at a time; the response returns to its owner.
module bsg_axil_master_arbiter #(
  parameter int unsigned num_req_p    = 2,
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 32
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p-1:0]                   req_w_i,
  input  logic [num_req_p*addr_width_p-1:0]      req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]      req_data_i,
  input  logic [num_req_p*(data_width_p/8)-1:0]  req_strb_i,
  output logic [num_req_p-1:0]                   req_yumi_o,
  output logic [num_req_p-1:0]                   resp_v_o,
  output logic [data_width_p-1:0]                resp_data_o,
  output logic                                   resp_err_o,
  input  logic [num_req_p-1:0]                   resp_ready_i,
  output logic [addr_width_p-1:0]                awaddr_o,
  output logic [2:0]                             awprot_o,
  output logic                                   awvalid_o,
  input  logic                                   awready_i,
  output logic [data_width_p-1:0]                wdata_o,
  output logic [data_width_p/8-1:0]              wstrb_o,
  output logic                                   wvalid_o,
  input  logic                                   wready_i,
  input  logic [1:0]                             bresp_i,
  input  logic                                   bvalid_i,
  output logic                                   bready_o,
  output logic [addr_width_p-1:0]                araddr_o,
  output logic [2:0]                             arprot_o,
  output logic                                   arvalid_o,
  input  logic                                   arready_i,
  input  logic [data_width_p-1:0]                rdata_i,
  input  logic [1:0]                             rresp_i,
  input  logic                                   rvalid_i,
  output logic                                   rready_o
);

  localparam int unsigned strb_width_lp = data_width_p / 8;
  localparam int unsigned lg_req_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_e;

  state_e                     state_r, state_n;
  logic [lg_req_lp-1:0]       last_grant_r, owner_r, grant;
  logic                       grant_v;
  logic [addr_width_p-1:0]    addr_r;
  logic [data_width_p-1:0]    data_r, resp_data_r;
  logic [strb_width_lp-1:0]   strb_r;
  logic                       resp_err_r;
  logic                       aw_done_r, w_done_r;
  logic                       aw_hs, w_hs;
  logic                       accept;

  // Round-robin pick: first valid requester after the last grant, wrapping.
  always_comb begin
    int unsigned cand;
    grant_v = 1'b0;
    grant   = '0;
    cand    = 0;
    for (int unsigned i = 1; i <= num_req_p; i++) begin
      cand = (32'(last_grant_r) + i) % num_req_p;
      if (!grant_v && req_v_i[lg_req_lp'(cand)]) begin
        grant_v = 1'b1;
        grant   = lg_req_lp'(cand);
      end
    end
  end

  assign accept = (state_r == IDLE) && grant_v;
  assign aw_hs  = awvalid_o && awready_i;
  assign w_hs   = wvalid_o && wready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (grant_v) state_n = req_w_i[grant] ? WRITE : READ;
      WRITE:   if ((aw_done_r || aw_hs) && (w_done_r || w_hs)) state_n = WRESP;
      WRESP:   if (bvalid_i) state_n = RESP;
      READ:    if (arready_i) state_n = RDATA;
      RDATA:   if (rvalid_i) state_n = RESP;
      RESP:    if (resp_ready_i[owner_r]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Channel controls decode from registered state so reset drops them at once.
  always_comb begin
    req_yumi_o = '0;
    resp_v_o   = '0;
    if (accept) req_yumi_o[grant] = 1'b1;
    if (state_r == RESP) resp_v_o[owner_r] = 1'b1;
    awvalid_o = (state_r == WRITE) && !aw_done_r;
    wvalid_o  = (state_r == WRITE) && !w_done_r;
    bready_o  = (state_r == WRESP);
    arvalid_o = (state_r == READ);
    rready_o  = (state_r == RDATA);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant_r <= lg_req_lp'(num_req_p - 1);
      owner_r      <= '0;
      addr_r       <= '0;
      data_r       <= '0;
      strb_r       <= '0;
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_r <= grant;
        owner_r      <= grant;
        addr_r       <= req_addr_i[grant*addr_width_p +: addr_width_p];
        data_r       <= req_data_i[grant*data_width_p +: data_width_p];
        strb_r       <= req_strb_i[grant*strb_width_lp +: strb_width_lp];
        aw_done_r    <= 1'b0;
        w_done_r     <= 1'b0;
      end
      if (aw_hs) aw_done_r <= 1'b1;
      if (w_hs)  w_done_r  <= 1'b1;
      if (bready_o && bvalid_i) begin
        resp_data_r <= '0;
        resp_err_r  <= (bresp_i != 2'b00);
      end
      if (rready_o && rvalid_i) begin
        resp_data_r <= rdata_i;
        resp_err_r  <= (rresp_i != 2'b00);
      end
    end
  end

  assign awaddr_o    = addr_r;
  assign araddr_o    = addr_r;
  assign wdata_o     = data_r;
  assign wstrb_o     = strb_r;
  assign awprot_o    = 3'b000;
  assign arprot_o    = 3'b000;
  assign resp_data_o = resp_data_r;
  assign resp_err_o  = resp_err_r;

endmodule
